// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
// One requester port of the RAM arbiter (CPU or program loader).
//
// Handshake: the requester raises req with we/addr/wdata stable and holds
// them until it sees ack. ack is a one-cycle pulse. rdata is valid in the
// ack cycle and holds until the next ack on this port. If req is still high
// in the cycle after ack, that is a new transaction.
//
// Signals:
//   req   requester -> arbiter  transaction request
//   we    requester -> arbiter  1=write, 0=read
//   addr  requester -> arbiter  32-bit word address
//   wdata requester -> arbiter  write data
//   ack   arbiter -> requester  one-cycle completion pulse
//   rdata arbiter -> requester  read data (0 for writes / bad addresses)
// Modports: master = requester side, slave = arbiter side.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [31:0]           addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, output we, output addr, output wdata,
                  input ack, input rdata);
  modport slave  (input req, input we, input addr, input wdata,
                  output ack, output rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares a single-port synchronous-read RAM between the CPU memory path and
// a program-loader/debug port. Each transaction takes three cycles:
// IDLE (arbitrate and latch), ACCESS (drive the RAM), RESP (ack and data).
// When both ports request in IDLE, the port that was not served last wins.
// Addresses with any bit set above ADDR_WIDTH never reach the RAM. They
// still complete, with addr_err raised in the ack cycle and rdata=0.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   cpu, ldr      requester ports (slave side of ram_port_arbiter_if)
//   ram_addr      RAM address, holds the latched address of the current grant
//   ram_data_in   RAM write data, holds the latched write data
//   ram_write     RAM write enable, only in ACCESS for in-range writes
//   ram_data_out  RAM read data, valid the cycle after the address
//   owner         0=CPU, 1=loader; port of the current or most recent grant
//   busy          high whenever a transaction is in progress
//   addr_err      one-cycle pulse with ack for an out-of-range address
//   state_o       current FSM state (debug)
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_port_arbiter_if.slave     cpu,
  ram_port_arbiter_if.slave     ldr,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  owner,
  output logic                  busy,
  output logic                  addr_err,
  output logic [1:0]            state_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] ldr_rdata_q, ldr_rdata_d;

  logic                  pick;
  logic [31:0]           sel_addr;
  logic [DATA_WIDTH-1:0] resp_val;
  logic                  in_resp;

  // With both ports requesting, serve the one that was not served last;
  // otherwise serve whichever is requesting.
  assign pick     = (cpu.req && ldr.req) ? ~last_q : ldr.req;
  assign sel_addr = pick ? ldr.addr : cpu.addr;

  // ram_data_out is valid in RESP because the address went out in ACCESS.
  assign resp_val = (!we_q && !err_q) ? ram_data_out : '0;

  // Reset is folded in combinationally so a reset in ACCESS stops the write
  // at the same edge, and a reset in RESP suppresses the ack.
  assign in_resp = (state_q == S_RESP) && !reset;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu.req || ldr.req) begin
          owner_d = pick;
          we_d    = pick ? ldr.we : cpu.we;
          addr_d  = sel_addr[ADDR_WIDTH-1:0];
          wdata_d = pick ? ldr.wdata : cpu.wdata;
          err_d   = |sel_addr[31:ADDR_WIDTH];
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (owner_q == PORT_LDR) begin
          ldr_rdata_d = resp_val;
        end else begin
          cpu_rdata_d = resp_val;
        end
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= PORT_CPU;
      last_q      <= PORT_LDR;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  assign ram_addr    = addr_q;
  assign ram_data_in = wdata_q;
  assign ram_write   = (state_q == S_ACCESS) && we_q && !err_q && !reset;

  assign cpu.ack   = in_resp && (owner_q == PORT_CPU);
  assign ldr.ack   = in_resp && (owner_q == PORT_LDR);
  // In the ack cycle the response is forwarded directly. The register
  // captures it at the same edge and holds it until the next ack.
  assign cpu.rdata = cpu.ack ? resp_val : cpu_rdata_q;
  assign ldr.rdata = ldr.ack ? resp_val : ldr_rdata_q;

  assign owner    = owner_q;
  assign busy     = (state_q != S_IDLE);
  assign addr_err = in_resp && err_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Directed bench for ram_port_arbiter. The bench has a behavioural RAM
// (ram_mem) for the DUT and a transaction-level reference model (ref_mem,
// round-robin order) that fills an expected-ack queue and an
// expected-write queue. A negedge compare process checks every cycle:
// acks, owner, addr_err, held rdata and each RAM write strobe.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  ram_addr;
  logic [31:0] ram_data_in;
  logic        ram_write;
  logic [31:0] ram_data_out;
  logic        owner;
  logic        busy;
  logic        addr_err;
  logic [1:0]  dbg_state;

  ram_port_arbiter_if #(.DATA_WIDTH(32)) cpu_if ();
  ram_port_arbiter_if #(.DATA_WIDTH(32)) ldr_if ();

  ram_port_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu          (cpu_if),
    .ldr          (ldr_if),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_write    (ram_write),
    .ram_data_out (ram_data_out),
    .owner        (owner),
    .busy         (busy),
    .addr_err     (addr_err),
    .state_o      (dbg_state)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM seen by the DUT.
  logic [31:0] ram_mem [512];
  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_addr] <= ram_data_in;
    ram_data_out <= ram_mem[ram_addr];
  end

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  logic [33:0] exp_q[$];   // {port, err, rdata}
  logic [40:0] wr_q[$];    // {addr, data}
  logic [31:0] ref_mem [512];
  logic        last_m = 1'b1;
  int          exp_wr = 0;
  int          wr_cycles = 0;
  logic [31:0] hold_c = '0;
  logic [31:0] hold_l = '0;
  logic        started = 1'b0;

  function automatic void predict(input logic port, input logic we,
                                  input logic [31:0] addr, input logic [31:0] wd);
    logic        err;
    logic [31:0] rd;
    err = (addr > 32'd511);
    rd  = (we || err) ? 32'h0 : ref_mem[addr[8:0]];
    if (we && !err) begin
      ref_mem[addr[8:0]] = wd;
      wr_q.push_back({addr[8:0], wd});
      exp_wr++;
    end
    exp_q.push_back({port, err, rd});
    last_m = port;
  endfunction

  always @(negedge clk) begin
    logic [33:0] e;
    logic [40:0] w;
    if (started) begin
      chk("single_ack", {63'b0, cpu_if.ack & ldr_if.ack}, 64'd0);
      if (cpu_if.ack || ldr_if.ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_port", {63'b0, ldr_if.ack}, {63'b0, e[33]});
          chk("owner_at_ack", {63'b0, owner}, {63'b0, e[33]});
          chk("addr_err_at_ack", {63'b0, addr_err}, {63'b0, e[32]});
          chk("busy_at_ack", {63'b0, busy}, 64'd1);
          if (ldr_if.ack) begin
            chk("ldr_rdata", {32'b0, ldr_if.rdata}, {32'b0, e[31:0]});
            hold_l = e[31:0];
          end else begin
            chk("cpu_rdata", {32'b0, cpu_if.rdata}, {32'b0, e[31:0]});
            hold_c = e[31:0];
          end
        end
      end else begin
        chk("addr_err_no_ack", {63'b0, addr_err}, 64'd0);
      end
      if (reset) begin
        hold_c = '0;
        hold_l = '0;
      end else begin
        if (!cpu_if.ack) chk("cpu_rdata_hold", {32'b0, cpu_if.rdata}, {32'b0, hold_c});
        if (!ldr_if.ack) chk("ldr_rdata_hold", {32'b0, ldr_if.rdata}, {32'b0, hold_l});
      end
      if (ram_write) begin
        wr_cycles++;
        if (wr_q.size() == 0) begin
          chk("unexpected_ram_write", 64'd1, 64'd0);
        end else begin
          w = wr_q.pop_front();
          chk("ram_write_addr", {55'b0, ram_addr}, {55'b0, w[40:32]});
          chk("ram_write_data", {32'b0, ram_data_in}, {32'b0, w[31:0]});
        end
      end
    end
  end

  // ---------------- driver ----------------
  logic        c_we [4];
  logic [31:0] c_addr [4];
  logic [31:0] c_wd [4];
  logic        l_we [4];
  logic [31:0] l_addr [4];
  logic [31:0] l_wd [4];
  int          nc = 0;
  int          nl = 0;
  logic        chg = 1'b0;
  logic [31:0] chg_addr = '0;
  logic [31:0] chg_wd = '0;
  logic [3:0]  last_hist = '0;

  // Runs the queued transactions of both ports. Each port keeps req high and
  // moves to its next transaction right after each ack.
  task automatic run_streams();
    int ic, il, cyc0, prev, n;
    logic cpu_done, ldr_done;
    logic [3:0] hist;
    ic = 0; il = 0;
    while (ic < nc || il < nl) begin
      if (ic < nc && (il >= nl || last_m == 1'b1)) begin
        predict(1'b0, c_we[ic], c_addr[ic], c_wd[ic]); ic++;
      end else begin
        predict(1'b1, l_we[il], l_addr[il], l_wd[il]); il++;
      end
    end
    @(posedge clk); #1;
    ic = 0; il = 0;
    if (nc > 0) begin
      cpu_if.req = 1'b1; cpu_if.we = c_we[0]; cpu_if.addr = c_addr[0]; cpu_if.wdata = c_wd[0];
    end
    if (nl > 0) begin
      ldr_if.req = 1'b1; ldr_if.we = l_we[0]; ldr_if.addr = l_addr[0]; ldr_if.wdata = l_wd[0];
    end
    cyc0 = cyc; prev = -1; hist = '0; n = 0;
    while ((ic < nc || il < nl) && n < 100) begin
      @(negedge clk);
      cpu_done = cpu_if.ack;
      ldr_done = ldr_if.ack;
      if (cpu_done || ldr_done) begin
        if (prev < 0) chk("first_ack_latency", 64'(cyc - cyc0), 64'd2);
        else          chk("ack_spacing", 64'(cyc - prev), 64'd3);
        prev = cyc;
        hist = {hist[2:0], ldr_done};
      end
      @(posedge clk); #1;
      n++;
      if (chg && n == 1) begin
        cpu_if.addr = chg_addr; cpu_if.wdata = chg_wd;
      end
      if (cpu_done) begin
        ic++;
        if (ic < nc) begin
          cpu_if.we = c_we[ic]; cpu_if.addr = c_addr[ic]; cpu_if.wdata = c_wd[ic];
        end else cpu_if.req = 1'b0;
      end
      if (ldr_done) begin
        il++;
        if (il < nl) begin
          ldr_if.we = l_we[il]; ldr_if.addr = l_addr[il]; ldr_if.wdata = l_wd[il];
        end else ldr_if.req = 1'b0;
      end
    end
    if (n >= 100) begin
      chk("stream_timeout", 64'd1, 64'd0);
      cpu_if.req = 1'b0; ldr_if.req = 1'b0;
    end
    last_hist = hist;
    nc = 0; nl = 0; chg = 1'b0;
  endtask

  task automatic cpu_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    c_we[0] = we; c_addr[0] = addr; c_wd[0] = wd; nc = 1; nl = 0;
    run_streams();
  endtask

  task automatic reset_dut();
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b0;
    last_m = 1'b1;
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
    ldr_if.req = 1'b0; ldr_if.we = 1'b0; ldr_if.addr = '0; ldr_if.wdata = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_owner", {63'b0, owner}, 64'd0);
    chk("rst_ram_write", {63'b0, ram_write}, 64'd0);
    chk("rst_ram_addr", {55'b0, ram_addr}, 64'd0);
    chk("rst_acks", {62'b0, cpu_if.ack, ldr_if.ack}, 64'd0);
    chk("rst_addr_err", {63'b0, addr_err}, 64'd0);
    chk("rst_cpu_rdata", {32'b0, cpu_if.rdata}, 64'd0);
    chk("rst_ldr_rdata", {32'b0, ldr_if.rdata}, 64'd0);
    @(posedge clk); #1; reset = 1'b0; started = 1'b1;

    // CPU write then read back.
    cpu_txn(1'b1, 32'h5, 32'hDEADBEEF);
    cpu_txn(1'b0, 32'h5, 32'h0);
    chk("pin_rd5", {32'b0, cpu_if.rdata}, 64'hDEADBEEF);

    // Loader preload with req held high across three writes.
    l_we[0] = 1'b1; l_addr[0] = 32'd0; l_wd[0] = 32'h11;
    l_we[1] = 1'b1; l_addr[1] = 32'd1; l_wd[1] = 32'h22;
    l_we[2] = 1'b1; l_addr[2] = 32'd2; l_wd[2] = 32'h33;
    nl = 3; nc = 0;
    run_streams();
    cpu_txn(1'b0, 32'd1, 32'h0);
    chk("pin_rd1", {32'b0, cpu_if.rdata}, 64'h22);

    // Both ports held for two transactions each, right after reset.
    reset_dut();
    c_we[0] = 1'b1; c_addr[0] = 32'h10; c_wd[0] = 32'hA0;
    c_we[1] = 1'b0; c_addr[1] = 32'h10; c_wd[1] = 32'h0;
    l_we[0] = 1'b1; l_addr[0] = 32'h20; l_wd[0] = 32'hB0;
    l_we[1] = 1'b0; l_addr[1] = 32'h0;  l_wd[1] = 32'h0;
    nc = 2; nl = 2;
    run_streams();
    chk("pin_order", {60'b0, last_hist}, 64'b0101);
    chk("pin_cpu_rd10", {32'b0, cpu_if.rdata}, 64'hA0);
    chk("pin_ldr_rd0", {32'b0, ldr_if.rdata}, 64'h11);

    // Out-of-range accesses.
    cpu_txn(1'b1, 32'h200, 32'h12345678);
    cpu_txn(1'b0, 32'h5, 32'h0);
    cpu_txn(1'b0, 32'hFFFF0000, 32'h0);
    chk("pin_oor_rdata", {32'b0, cpu_if.rdata}, 64'h0);

    // Reset during the ACCESS cycle of a loader write.
    cpu_txn(1'b1, 32'd7, 32'h77);
    @(posedge clk); #1;
    ldr_if.req = 1'b1; ldr_if.we = 1'b1; ldr_if.addr = 32'd7; ldr_if.wdata = 32'hBAD;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    chk("abort_busy_in_access", {63'b0, busy}, 64'd1);
    chk("abort_no_write", {63'b0, ram_write}, 64'd0);
    @(posedge clk); #1; reset = 1'b0; ldr_if.req = 1'b0; last_m = 1'b1;
    @(negedge clk);
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_ldr_ack", {63'b0, ldr_if.ack}, 64'd0);
    chk("abort_owner", {63'b0, owner}, 64'd0);
    cpu_txn(1'b0, 32'd7, 32'h0);
    chk("pin_rd7_old", {32'b0, cpu_if.rdata}, 64'h77);

    // Address/data changed the cycle after grant: the latched values win.
    c_we[0] = 1'b1; c_addr[0] = 32'd3; c_wd[0] = 32'hAA; nc = 1; nl = 0;
    chg = 1'b1; chg_addr = 32'd4; chg_wd = 32'hBB;
    run_streams();
    cpu_txn(1'b0, 32'd3, 32'h0);
    chk("pin_rd3", {32'b0, cpu_if.rdata}, 64'hAA);

    // Final report.
    repeat (3) @(posedge clk);
    chk("write_count", 64'(wr_cycles), 64'(exp_wr));
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 512x32 RAM between two requesters: the CPU memory interface (MAR/MDR path, driven by control_unit) and a program-loader/debug port.
- Sits between the requesters and ram_512x32 and owns the RAM's address, write-data and write-enable inputs.
- Uses a req/ack handshake per port, round-robin arbitration when both ports request, and a fixed 3-cycle transaction.
- Rejects out-of-range addresses without touching RAM.

Parameters:
ADDR_WIDTH, 9, RAM address width; RAM depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
cpu_req  input  1  CPU transaction request, held until cpu_ack
cpu_we  input  1  1=write, 0=read; stable while cpu_req=1
cpu_addr  input  32  word address (from MAR); stable while cpu_req=1
cpu_wdata  input  DATA_WIDTH  write data (from MDR); stable while cpu_req=1
cpu_ack  output  1  one-cycle completion pulse
cpu_rdata  output  DATA_WIDTH  read data, valid in the cpu_ack cycle
ldr_req  input  1  loader request, same rules as cpu_req
ldr_we  input  1  loader write select
ldr_addr  input  32  loader word address
ldr_wdata  input  DATA_WIDTH  loader write data
ldr_ack  output  1  one-cycle completion pulse
ldr_rdata  output  DATA_WIDTH  read data, valid in the ldr_ack cycle
ram_addr  output  ADDR_WIDTH  to RAM addr
ram_data_in  output  DATA_WIDTH  to RAM data_in
ram_write  output  1  to RAM write_enable
ram_data_out  input  DATA_WIDTH  from RAM data_out (synchronous read: valid the cycle after the address)
owner  output  1  0=CPU, 1=loader; port of the current or most recent grant
busy  output  1  1 whenever state != IDLE
addr_err  output  1  one-cycle pulse coincident with ack when the granted address is out of range

Behaviour:
- Reset (synchronous, active-high) sets state=IDLE, all outputs 0, ram_addr=0, owner=0, last_served=LDR, so the CPU wins the first tie. Reset has priority over every other event.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one req: grant that port.
- IDLE, both reqs: grant the port != last_served.
- On grant, latch the port's we, addr[ADDR_WIDTH-1:0], wdata and range flag into internal registers, set owner, then go to ACCESS.
  - Range flag is (addr[31:ADDR_WIDTH] != 0).
- ACCESS:
  - ram_addr drives the latched address.
  - ram_write=1 for this single cycle only if latched we=1 and the address is in range.
  - Go to RESP.
- RESP:
  - Assert ack on the owner port for exactly one cycle.
  - For a read: rdata = ram_data_out if in range, else 0.
  - For a write: rdata = 0.
  - addr_err=1 if the address was out of range.
  - Update last_served=owner, then go to IDLE.
- rdata is registered and holds its value until the next ack on that port.
- ram_write is 0 in every state other than ACCESS.
- Fixed latency: grant edge to ack = 2 cycles after IDLE. Each transaction takes 3 cycles. Maximum throughput is one transaction per 3 cycles.
- Requests arriving during ACCESS or RESP are only sampled in IDLE.
- A port whose req is still high in the cycle after its ack is treated as a new transaction. With the other port pending, it loses the tie (strict alternation, no starvation).
- Only the IDLE-cycle values of we/addr/wdata matter. Changes after grant are ignored because the values are latched.
- ram_data_in is driven from the latched wdata throughout ACCESS.
- Reset during ACCESS: ram_write deasserts in the reset cycle's result (RAM sees the write only if it was already clocked). State returns to IDLE with no ack issued; the requester re-requests.
- Reset during RESP: the ack is suppressed.

Test Plan:
- Reset, then write path: CPU write addr=0x5, wdata=0xDEADBEEF. Required: ram_write=1 exactly 1 cycle with ram_addr=5; cpu_ack 2 cycles after grant. Then CPU read addr=0x5 → cpu_rdata=0xDEADBEEF in the ack cycle, addr_err=0.
- Loader preload: loader writes 0x11,0x22,0x33 to addrs 0..2, req held high continuously. Required: 3 ldr_acks spaced exactly 3 cycles apart. A CPU read of addr 1 afterwards returns 0x22.
- Simultaneous req in the same cycle after reset (both held for 4 transactions). Required: grant order CPU, LDR, CPU, LDR; owner toggles; no port gets two consecutive acks.
- Out-of-range: CPU write addr=0x200 and read addr=0xFFFF0000. Required: ram_write stays 0; ack still issued; addr_err=1 in the ack cycle; cpu_rdata=0.
- Reset asserted in the ACCESS cycle of a loader write to addr 7. Required: next cycle busy=0, no ldr_ack, owner=0. A subsequent CPU read of addr 7 returns the old contents.
- Address/data changed one cycle after grant (addr 3→4). Required: the RAM access uses addr 3.
